dmem_ctrl: RTL and testbench

Data-memory controller that terminates the core's data-memory valid/ready port, which the load/store unit drives. It serves word-wide, byte-lane-masked reads and writes from an on-chip synchronous SRAM after a programmable number of wait states. It returns read data on a single-cycle ready pulse. It sits directly downstream of the load/store unit; the unit's `done` is this block's `dmem_ready_o`.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_sram.sv | 90 +++++++++
 rtl/riscv_defines.sv | 8 +
 rtl/dmem_ctrl.sv | 104 ++++++++++
 tb/tb_dmem_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

  // Wait-state counter width; covers WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Number of word-index bits needed to address a SRAM of the given depth.
  function automatic int idx_width(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word SRAM with byte-lane write enables and a
// registered read port. Optional per-lane even parity under DMEM_PARITY_EN.
`include "riscv_defines.sv"

module dmem_sram
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [3:0]                      we_i,
  input  logic [idx_width(MEM_WORDS)-1:0] idx_i,
  input  logic [`RISCV_WORD_WIDTH-1:0]    wdata_i,
  output logic [`RISCV_WORD_WIDTH-1:0]    rdata_o,
  output logic                            err_o
);

  localparam int IDX_W = idx_width(MEM_WORDS);

  logic [`RISCV_WORD_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [`RISCV_WORD_WIDTH-1:0] rdata_d, rdata_q;
  logic                         rd_en, wr_en;

  // A reset coinciding with the access edge suppresses the write.
  assign wr_en = en_i && !rst && (we_i != 4'h0);
  assign rd_en = en_i && (we_i == 4'h0);

  // Byte-lane masked write of the data array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register only updates on reads, so it holds across writes.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_q[idx_i];
  end

  // Read data register with reset to zero.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [MEM_WORDS];
  logic       err_d, err_q;

  // Store even parity per enabled lane alongside the data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we_i[i]) par_mem[idx_i][i] <= ^wdata_i[8*i +: 8];
      end
    end
  end

  // Check all four lanes on a read; writes clear the flag.
  always_comb begin
    err_d = err_q;
    if (rd_en) begin
      err_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        err_d = err_d | ((^mem_q[idx_i][8*i +: 8]) ^ par_mem[idx_i][i]);
      end
    end else if (en_i) begin
      err_d = 1'b0;
    end
  end

  // Parity error register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/riscv_defines.sv
// Core-wide address and data word widths shared by the RISC-V blocks.
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV

`define RISCV_ADDR_WIDTH 32
`define RISCV_WORD_WIDTH 32

`endif

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready slave port in front of dmem_sram with
// a programmable number of wait states. Parity checking is enabled by
// defining DMEM_PARITY_EN.
`include "riscv_defines.sv"

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_valid_i,
  output logic                          dmem_ready_o,
  input  logic [`RISCV_ADDR_WIDTH-1:0]  dmem_addr_i,
  input  logic [`RISCV_WORD_WIDTH-1:0]  dmem_wdata_i,
  input  logic [3:0]                    dmem_we_i,
  output logic [`RISCV_WORD_WIDTH-1:0]  dmem_rdata_o,
  output logic                          dmem_err_o
);

  localparam int IDX_W = idx_width(MEM_WORDS);

  dmem_state_e                  state_d, state_q;
  logic [CNT_W-1:0]             cnt_d, cnt_q;
  logic [IDX_W-1:0]             idx_d, idx_q;
  logic [3:0]                   we_d, we_q;
  logic [`RISCV_WORD_WIDTH-1:0] wdata_d, wdata_q;
  logic                         sram_en;
  logic                         sram_err;
  logic                         unused_addr_bits;

  // Only the word-index bits are kept; the rest alias away.
  assign unused_addr_bits = ^{dmem_addr_i[`RISCV_ADDR_WIDTH-1:IDX_W+2], dmem_addr_i[1:0]};

  // Next-state, request capture and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    sram_en      = 1'b0;
    dmem_ready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dmem_valid_i) begin
          idx_d   = dmem_addr_i[IDX_W+1:2];
          we_d    = dmem_we_i;
          wdata_d = dmem_wdata_i;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        sram_en = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        dmem_ready_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  dmem_sram #(
    .MEM_WORDS (MEM_WORDS)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (sram_en),
    .we_i    (we_q),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (dmem_rdata_o),
    .err_o   (sram_err)
  );

  assign dmem_err_o = dmem_ready_o & sram_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl; instance 0 uses one wait
// state, instance 1 uses none.
`include "riscv_defines.sv"

module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        valid   [2];
  logic        ready   [2];
  logic [31:0] addr_i  [2];
  logic [31:0] wdata_i [2];
  logic [3:0]  we_i    [2];
  logic [31:0] rdata   [2];
  logic        err     [2];

  int n_cmp;
  int n_fail;

  logic [31:0] rd;
  logic        er;
  int          pulses;
  int          consec;
  logic        prev;
  logic [31:0] last_rd;

  dmem_ctrl #(
    .MEM_WORDS   (1024),
    .WAIT_CYCLES (1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_valid_i (valid[0]),
    .dmem_ready_o (ready[0]),
    .dmem_addr_i  (addr_i[0]),
    .dmem_wdata_i (wdata_i[0]),
    .dmem_we_i    (we_i[0]),
    .dmem_rdata_o (rdata[0]),
    .dmem_err_o   (err[0])
  );

  dmem_ctrl #(
    .MEM_WORDS   (1024),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .dmem_valid_i (valid[1]),
    .dmem_ready_o (ready[1]),
    .dmem_addr_i  (addr_i[1]),
    .dmem_wdata_i (wdata_i[1]),
    .dmem_we_i    (we_i[1]),
    .dmem_rdata_o (rdata[1]),
    .dmem_err_o   (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; request fields are scrambled after capture to show
  // that only the latched copy is used.
  task automatic txn(input int inst, input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, input string tag,
                     output logic [31:0] rdo, output logic erro);
    int lat;
    int exp_lat;
    exp_lat = (inst == 0) ? 3 : 2;
    lat = 0;
    @(negedge clk);
    valid[inst]   = 1'b1;
    addr_i[inst]  = a;
    we_i[inst]    = w;
    wdata_i[inst] = d;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        addr_i[inst]  = ~a;
        wdata_i[inst] = ~d;
        we_i[inst]    = ~w;
      end
      if (ready[inst]) lat = n;
    end
    rdo  = rdata[inst];
    erro = err[inst];
    valid[inst] = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "_ready_drop"}, {31'h0, ready[inst]}, 32'h0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 2; i++) begin
      valid[i]   = 1'b0;
      addr_i[i]  = '0;
      wdata_i[i] = '0;
      we_i[i]    = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("idle_ready", {31'h0, ready[0]}, 32'h0);
      check("idle_rdata", rdata[0], 32'h0);
      check("idle_err", {31'h0, err[0]}, 32'h0);
    end
    check("idle_ready_w0", {31'h0, ready[1]}, 32'h0);
    check("idle_rdata_w0", rdata[1], 32'h0);

    // Full-word write then read.
    txn(0, 32'h10, 4'hF, 32'hDEADBEEF, "wr10", rd, er);
    check("wr10_err", {31'h0, er}, 32'h0);
    txn(0, 32'h10, 4'h0, 32'h0, "rd10", rd, er);
    check("rd10_data", rd, 32'hDEADBEEF);
    check("rd10_err", {31'h0, er}, 32'h0);

    // Byte-lane merge.
    txn(0, 32'h20, 4'hF, 32'h11223344, "pre20", rd, er);
    txn(0, 32'h20, 4'b0100, 32'h00AA0000, "lane20", rd, er);
    txn(0, 32'h20, 4'h0, 32'h0, "rd20", rd, er);
    check("rd20_data", rd, 32'h11AA3344);
    txn(0, 32'h24, 4'hF, 32'hCAFEF00D, "wr24", rd, er);
    check("rdata_hold", rd, 32'h11AA3344);

    // Same on the zero-wait instance.
    txn(1, 32'h20, 4'hF, 32'h11223344, "w0_pre20", rd, er);
    txn(1, 32'h20, 4'b0100, 32'h00AA0000, "w0_lane20", rd, er);
    txn(1, 32'h20, 4'h0, 32'h0, "w0_rd20", rd, er);
    check("w0_rd20_data", rd, 32'h11AA3344);

    // Address aliasing modulo 1024 words.
    txn(0, 32'h1010, 4'hF, 32'h5A5A5A5A, "wr1010", rd, er);
    txn(0, 32'h0010, 4'h0, 32'h0, "rd0010", rd, er);
    check("alias_data", rd, 32'h5A5A5A5A);

    // Held valid: one pulse every WAIT_CYCLES+3 cycles.
    @(negedge clk);
    valid[0]  = 1'b1;
    addr_i[0] = 32'h10;
    we_i[0]   = 4'h0;
    pulses = 0;
    consec = 0;
    prev   = 1'b0;
    last_rd = '0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      if (ready[0]) begin
        pulses++;
        last_rd = rdata[0];
        if (prev) consec++;
      end
      prev = ready[0];
    end
    valid[0] = 1'b0;
    check("held_pulses", 32'(pulses), 32'd4);
    check("held_consec", 32'(consec), 32'd0);
    check("held_data", last_rd, 32'h5A5A5A5A);
    repeat (2) @(posedge clk);

    // Reset abort in the ACCESS cycle.
    txn(0, 32'h30, 4'hF, 32'h0, "pre30", rd, er);
    @(negedge clk);
    valid[0]   = 1'b1;
    addr_i[0]  = 32'h30;
    we_i[0]    = 4'hF;
    wdata_i[0] = 32'hFFFFFFFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    valid[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", {31'h0, ready[0]}, 32'h0);
    check("abort_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (ready[0]) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    txn(0, 32'h30, 4'h0, 32'h0, "rd30", rd, er);
    check("abort_no_write", rd, 32'h0);

`ifdef DMEM_PARITY_EN
    txn(0, 32'h40, 4'hF, 32'h01020304, "par_wr", rd, er);
    check("par_wr_err", {31'h0, er}, 32'h0);
    @(negedge clk);
    u_dut.u_sram.par_mem[16] = u_dut.u_sram.par_mem[16] ^ 4'b0100;
    txn(0, 32'h40, 4'h0, 32'h0, "par_rd", rd, er);
    check("par_err_set", {31'h0, er}, 32'h1);
    check("par_rd_data", rd, 32'h01020304);
    txn(0, 32'h40, 4'hF, 32'h01020304, "par_rewr", rd, er);
    txn(0, 32'h40, 4'h0, 32'h0, "par_rerd", rd, er);
    check("par_err_clear", {31'h0, er}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
